// File: rtl/bcd_pkg.sv
// Purpose: shared BCD constants, digit type and nibble clamp for the counter/scanner.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
//
// Contents:
//   BCD_MAX     largest legal BCD digit value
//   NUM_DIGITS  number of digits in the counter
//   bcd_digit_t one BCD nibble
//   bcd_clamp   forces any nibble above 9 down to 9
package bcd_pkg;

    localparam logic [3:0] BCD_MAX    = 4'd9;
    localparam int         NUM_DIGITS = 4;

    typedef logic [3:0] bcd_digit_t;

    function automatic bcd_digit_t bcd_clamp(input bcd_digit_t d);
        return (d > BCD_MAX) ? BCD_MAX : d;
    endfunction

endpackage

// File: rtl/bcd_digit_cell.sv
// Purpose: one BCD digit of the up/down counter, with ripple carry/borrow out.
// Latency: digit updates on the edge after inc/dec/load; carry/borrow are combinational.
// Backpressure: none; inc/dec/load are accepted every cycle.
//
// Ports:
//   i_clk, i_rst        clock, synchronous active-high reset
//   i_inc, i_dec        step this digit up/down (never both high)
//   i_load, i_load_d    load a value (clamped to 9); wins over inc/dec
//   o_digit             registered digit value
//   o_carry, o_borrow   this digit wraps on the current inc/dec (feeds next digit)
module bcd_digit_cell
    import bcd_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_inc,
    input  logic       i_dec,
    input  logic       i_load,
    input  logic [3:0] i_load_d,
    output logic [3:0] o_digit,
    output logic       o_carry,
    output logic       o_borrow
);

    bcd_digit_t r_digit;

    // Carry/borrow are only meaningful when this digit is actually stepping,
    // so the upstream digit's wrap ripples through in the same cycle.
    assign o_carry  = i_inc && (r_digit == BCD_MAX);
    assign o_borrow = i_dec && (r_digit == 4'd0);
    assign o_digit  = r_digit;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_digit <= 4'd0;
        end else if (i_load) begin
            r_digit <= bcd_clamp(i_load_d);
        end else if (i_inc) begin
            r_digit <= (r_digit == BCD_MAX) ? 4'd0 : r_digit + 4'd1;
        end else if (i_dec) begin
            r_digit <= (r_digit == 4'd0) ? BCD_MAX : r_digit - 4'd1;
        end
    end

endmodule

// File: rtl/bcd_count_scanner.sv
// Purpose: 4-digit BCD up/down counter plus time-multiplexed digit scanner for a 7-seg driver.
// Latency: count/ovf 1 cycle after tick or load; bcd/an trail count and digit_sel by 1 cycle.
// Backpressure: none; count rate set by CNT_DIV prescaler (gated by i_en), scan rate by SCAN_DIV.
//
// Ports:
//   i_clk, i_rst     clock, synchronous active-high reset
//   i_en             enables the count prescaler only
//   i_up_dn          1 = count up, 0 = count down
//   i_load, i_load_val  load four BCD digits ([3:0] = digit 0), nibbles >9 clamp to 9
//   o_count          registered count, BCD
//   o_ovf            one-cycle pulse on 9999->0000 or 0000->9999
//   o_bcd, o_an      selected digit and active-low one-hot anode select
//   o_digit_sel      index of the digit being scanned
module bcd_count_scanner
    import bcd_pkg::*;
#(
    parameter int CNT_DIV  = 100_000_000,
    parameter int SCAN_DIV = 100_000
)
(
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_en,
    input  logic        i_up_dn,
    input  logic        i_load,
    input  logic [15:0] i_load_val,
    output logic [15:0] o_count,
    output logic        o_ovf,
    output logic [3:0]  o_bcd,
    output logic [3:0]  o_an,
    output logic [1:0]  o_digit_sel
);

    // A divider of 1 would give a zero-width counter; keep at least one bit.
    localparam int CW = (CNT_DIV  > 1) ? $clog2(CNT_DIV)  : 1;
    localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST  = CW'(CNT_DIV - 1);
    localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);

    logic [CW-1:0]         r_cnt_pre;
    logic [SW-1:0]         r_scan_pre;
    logic [1:0]            r_digit_sel;
    logic                  r_ovf;
    logic [3:0]            r_bcd;
    logic [3:0]            r_an;

    logic                  w_tick;
    logic [NUM_DIGITS:0]   w_inc;
    logic [NUM_DIGITS:0]   w_dec;
    bcd_digit_t            w_digit [NUM_DIGITS];

    assign w_tick = i_en && (r_cnt_pre == CNT_LAST);

    // Load outranks a tick, so the step request is masked at its source.
    assign w_inc[0] = w_tick &&  i_up_dn && !i_load;
    assign w_dec[0] = w_tick && !i_up_dn && !i_load;

    // ------------------------------------------------------------------
    // Count prescaler: load restarts the count period from zero.
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt_pre <= '0;
        end else if (i_load) begin
            r_cnt_pre <= '0;
        end else if (i_en) begin
            r_cnt_pre <= w_tick ? '0 : r_cnt_pre + CW'(1);
        end
    end

    // ------------------------------------------------------------------
    // Digit chain: carry/borrow out of digit g is the step into digit g+1.
    // ------------------------------------------------------------------
    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_digit
        bcd_digit_cell u_cell (
            .i_clk    (i_clk),
            .i_rst    (i_rst),
            .i_inc    (w_inc[g]),
            .i_dec    (w_dec[g]),
            .i_load   (i_load),
            .i_load_d (i_load_val[4*g +: 4]),
            .o_digit  (w_digit[g]),
            .o_carry  (w_inc[g+1]),
            .o_borrow (w_dec[g+1])
        );
        assign o_count[4*g +: 4] = w_digit[g];
    end

    // Ripple out of the top digit is the wrap; masked step inputs already
    // guarantee no pulse in a load cycle.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_ovf <= 1'b0;
        end else begin
            r_ovf <= w_inc[NUM_DIGITS] || w_dec[NUM_DIGITS];
        end
    end

    // ------------------------------------------------------------------
    // Scanner: free-running, unaffected by en/load.
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_scan_pre  <= '0;
            r_digit_sel <= 2'd0;
        end else if (r_scan_pre == SCAN_LAST) begin
            r_scan_pre  <= '0;
            r_digit_sel <= r_digit_sel + 2'd1;
        end else begin
            r_scan_pre  <= r_scan_pre + SW'(1);
        end
    end

    // bcd and an are registered together from the same select so the
    // display never shows a digit on the wrong anode.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_bcd <= 4'd0;
            r_an  <= 4'b1110;
        end else begin
            r_bcd <= w_digit[r_digit_sel];
            r_an  <= ~(4'b0001 << r_digit_sel);
        end
    end

    assign o_ovf       = r_ovf;
    assign o_bcd       = r_bcd;
    assign o_an        = r_an;
    assign o_digit_sel = r_digit_sel;

endmodule

// File: tb/tb_bcd_count_scanner.sv
// Purpose: self-checking bench for bcd_count_scanner (CNT_DIV=4, SCAN_DIV=2).
// Latency: expected outputs queued at each rising edge, compared at the following falling edge.
// Backpressure: n/a.
module tb_bcd_count_scanner;

    localparam int CNT_DIV  = 4;
    localparam int SCAN_DIV = 2;

    logic        clk;
    logic        rst;
    logic        en;
    logic        up_dn;
    logic        load;
    logic [15:0] load_val;
    logic [15:0] count;
    logic        ovf;
    logic [3:0]  bcd;
    logic [3:0]  an;
    logic [1:0]  digit_sel;

    int n_cmp = 0;
    int n_err = 0;

    bcd_count_scanner #(.CNT_DIV(CNT_DIV), .SCAN_DIV(SCAN_DIV)) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_en        (en),
        .i_up_dn     (up_dn),
        .i_load      (load),
        .i_load_val  (load_val),
        .o_count     (count),
        .o_ovf       (ovf),
        .o_bcd       (bcd),
        .o_an        (an),
        .o_digit_sel (digit_sel)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model (decimal integer arithmetic) and scoreboard queue.
    // ------------------------------------------------------------------
    typedef struct {
        logic [15:0] count;
        logic        ovf;
        logic [3:0]  bcd;
        logic [3:0]  an;
        logic [1:0]  sel;
    } exp_t;

    exp_t exp_q[$];

    int   m_val, m_pre, m_spre, m_sel;
    logic m_ovf;
    logic [3:0] m_bcd, m_an;

    function automatic logic [15:0] to_bcd(input int v);
        return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
    endfunction

    function automatic int from_bcd_clamp(input logic [15:0] x);
        int r = 0;
        for (int i = 3; i >= 0; i--) begin
            int nib = int'(x[4*i +: 4]);
            if (nib > 9) nib = 9;
            r = r * 10 + nib;
        end
        return r;
    endfunction

    function automatic int digit_of(input int v, input int idx);
        int p = 1;
        for (int i = 0; i < idx; i++) p = p * 10;
        return (v / p) % 10;
    endfunction

    always @(posedge clk) begin
        exp_t e;
        bit   tick;
        if (rst) begin
            m_val = 0; m_pre = 0; m_spre = 0; m_sel = 0;
            m_ovf = 1'b0; m_bcd = 4'd0; m_an = 4'b1110;
        end else begin
            tick  = en && (m_pre == CNT_DIV - 1);
            m_bcd = 4'(digit_of(m_val, m_sel));
            m_an  = ~(4'b0001 << m_sel);
            if (m_spre == SCAN_DIV - 1) begin
                m_spre = 0;
                m_sel  = (m_sel + 1) % 4;
            end else begin
                m_spre++;
            end
            if (load) begin
                m_val = from_bcd_clamp(load_val);
                m_pre = 0;
                m_ovf = 1'b0;
            end else if (tick) begin
                if (up_dn) begin
                    m_ovf = (m_val == 9999);
                    m_val = (m_val + 1) % 10000;
                end else begin
                    m_ovf = (m_val == 0);
                    m_val = (m_val + 9999) % 10000;
                end
                m_pre = 0;
            end else begin
                m_ovf = 1'b0;
                if (en) m_pre++;
            end
        end
        e.count = to_bcd(m_val);
        e.ovf   = m_ovf;
        e.bcd   = m_bcd;
        e.an    = m_an;
        e.sel   = 2'(m_sel);
        exp_q.push_back(e);
    end

    bit armed = 0;

    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("sb_count", 32'(count), 32'(e.count));
            chk("sb_ovf",   32'(ovf),   32'(e.ovf));
            chk("sb_bcd",   32'(bcd),   32'(e.bcd));
            chk("sb_an",    32'(an),    32'(e.an));
            chk("sb_sel",   32'(digit_sel), 32'(e.sel));
            chk("an_onehot", 32'($onehot(~an)), 32'd1);
            armed = 1;
        end
    end

    always @(negedge clk) begin
        if (armed) begin
            assert ($onehot(~an)) else $error("anode select not exactly one low: %b", an);
        end
    end

    // ------------------------------------------------------------------
    // Directed sequences
    // ------------------------------------------------------------------
    task automatic do_load(input logic [15:0] v);
        load     = 1'b1;
        load_val = v;
        @(negedge clk);
        load     = 1'b0;
    endtask

    // Number of falling edges until count differs from old (21 = never).
    task automatic wait_change(input logic [15:0] old, output int cyc);
        cyc = 0;
        for (int i = 0; i < 21; i++) begin
            @(negedge clk);
            cyc++;
            if (count !== old) break;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int   cyc;
        int   moves;
        bit   found;
        logic [15:0] saved;
        logic [1:0]  prev_sel;

        rst = 1'b1; en = 1'b0; up_dn = 1'b1; load = 1'b0; load_val = 16'h0000;

        // Reset
        repeat (3) @(negedge clk);
        chk("rst_count", 32'(count), 32'h0000);
        chk("rst_an",    32'(an),    32'hE);
        chk("rst_bcd",   32'(bcd),   32'h0);
        chk("rst_ovf",   32'(ovf),   32'h0);
        chk("rst_sel",   32'(digit_sel), 32'h0);
        rst = 1'b0; en = 1'b1;
        wait_change(16'h0000, cyc);
        chk("first_tick_lat", 32'(cyc), 32'd4);
        chk("first_tick_val", 32'(count), 32'h0001);

        // Up carry ripple and wrap
        do_load(16'h0999);
        chk("load_0999", 32'(count), 32'h0999);
        wait_change(16'h0999, cyc);
        chk("ripple_lat", 32'(cyc), 32'd4);
        chk("ripple_up", 32'(count), 32'h1000);
        chk("ripple_ovf", 32'(ovf), 32'h0);
        do_load(16'h9999);
        wait_change(16'h9999, cyc);
        chk("wrap_up", 32'(count), 32'h0000);
        chk("wrap_up_ovf", 32'(ovf), 32'h1);
        @(negedge clk);
        chk("wrap_up_ovf_clr", 32'(ovf), 32'h0);

        // Down borrow and wrap
        up_dn = 1'b0;
        do_load(16'h1000);
        wait_change(16'h1000, cyc);
        chk("borrow_dn", 32'(count), 32'h0999);
        chk("borrow_ovf", 32'(ovf), 32'h0);
        do_load(16'h0000);
        wait_change(16'h0000, cyc);
        chk("wrap_dn", 32'(count), 32'h9999);
        chk("wrap_dn_ovf", 32'(ovf), 32'h1);
        @(negedge clk);
        chk("wrap_dn_ovf_clr", 32'(ovf), 32'h0);

        // Load coincident with tick, with clamp
        up_dn = 1'b1;
        do_load(16'h0000);
        repeat (3) @(negedge clk);
        do_load(16'h3A5F);
        chk("load_clamp", 32'(count), 32'h3959);
        chk("load_no_ovf", 32'(ovf), 32'h0);
        wait_change(16'h3959, cyc);
        chk("load_pre_restart", 32'(cyc), 32'd4);
        chk("after_load_tick", 32'(count), 32'h3960);

        // en gating
        repeat (2) @(negedge clk);
        en = 1'b0;
        saved = count;
        prev_sel = digit_sel;
        moves = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (digit_sel !== prev_sel) moves++;
            prev_sel = digit_sel;
        end
        chk("en0_hold", 32'(count), 32'(saved));
        chk("en0_scan_moves", 32'(moves), 32'd10);
        en = 1'b1;
        wait_change(saved, cyc);
        chk("en1_remaining", 32'(cyc), 32'd2);
        chk("en1_val", 32'(count), 32'h3961);

        // Scan sequence
        en = 1'b0;
        do_load(16'h4321);
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            if (an === 4'b0111) found = 1;
        end
        chk("scan_sync_a", 32'(found), 32'd1);
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            if (an === 4'b1110) found = 1;
        end
        chk("scan_sync_b", 32'(found), 32'd1);
        for (int k = 0; k < 8; k++) begin
            logic [3:0] want_an;
            want_an = ~(4'b0001 << (k / 2));
            chk("scan_an",  32'(an),  32'(want_an));
            chk("scan_bcd", 32'(bcd), 32'(k / 2 + 1));
            @(negedge clk);
        end

        // Reset mid-operation beats a concurrent load and tick
        en = 1'b1; rst = 1'b1; load = 1'b1; load_val = 16'h5555;
        @(negedge clk);
        rst = 1'b0; load = 1'b0;
        chk("midrst_count", 32'(count), 32'h0000);
        chk("midrst_an", 32'(an), 32'hE);
        chk("midrst_sel", 32'(digit_sel), 32'h0);
        wait_change(16'h0000, cyc);
        chk("midrst_lat", 32'(cyc), 32'd4);

        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
